// File: rtl/router_fsm_nch.sv
// ---------------------------------------------------------------------------
// router_fsm_nch
//
// Control FSM for the 1xN packet router. It decodes the destination address
// carried in the header byte, latches a one-hot channel select for the whole
// packet, and sequences the header, payload and parity writes into the
// selected FIFO. It also handles the conditions that can stop a packet:
//   - headers that address a channel which does not exist are dropped,
//   - a soft reset on the selected channel abandons the packet,
//   - a watchdog abandons a packet that stalls for too long on a FIFO that
//     never drains.
//
// Parameters
//   NUM_CH          number of destination channels (2..16)
//   ADDR_W          width of the header address field, data_in[ADDR_W-1:0]
//   DATA_W          data bus width (>= ADDR_W)
//   TIMEOUT_CYCLES  stall limit in cycles; 0 disables the watchdog
//   TO_W            watchdog counter width (must hold TIMEOUT_CYCLES)
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   synchronous active-high reset
//   pkt_valid      in   source byte valid
//   data_in        in   source byte; the header carries the address
//   fifo_full      in   per-channel FIFO full flags
//   fifo_empty     in   per-channel FIFO empty flags
//   parity_done    in   parity byte has been captured
//   low_pkt_valid  in   pkt_valid fell while the FSM was stalled
//   soft_reset     in   per-channel soft reset from the read side
//   ch_sel         out  one-hot latched destination channel
//   busy .. rst_int_reg, drop_state
//                  out  Moore decodes of the current state
//   timeout_err    out  one-cycle pulse after a watchdog abort
// ---------------------------------------------------------------------------
module router_fsm_nch #(
  parameter int NUM_CH         = 3,
  parameter int ADDR_W         = $clog2(NUM_CH),
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W           = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [NUM_CH-1:0] fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  input  logic [NUM_CH-1:0] soft_reset,
  output logic [NUM_CH-1:0] ch_sel,
  output logic              busy,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              write_enb_reg,
  output logic              full_state,
  output logic              laf_state,
  output logic              rst_int_reg,
  output logic              drop_state,
  output logic              timeout_err
);

  typedef enum logic [3:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERR,
    DROP_PACKET
  } state_e;

  // The watchdog compares against TIMEOUT_CYCLES-1 so that an abort happens
  // after exactly TIMEOUT_CYCLES stall cycles. A zero limit turns it off.
  localparam bit            WD_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_W-1:0] WD_LIMIT =
    TO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] ch_sel_q, ch_sel_d;
  logic [TO_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              timeout_err_q, timeout_err_d;

  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic [NUM_CH-1:0] addr_onehot;
  logic              hdr_empty;
  logic              sel_full;
  logic              sel_empty;
  logic              sel_soft_rst;
  logic              in_stall;

  // Header decode. The one-hot of an out-of-range address shifts out to
  // zero, but it is only ever used once the address is known to be valid.
  // The header's empty check uses the freshly decoded address because
  // ch_sel_q still holds the previous packet's channel at this point.
  always_comb begin
    addr        = data_in[ADDR_W-1:0];
    addr_valid  = (32'(addr) < 32'(NUM_CH));
    addr_onehot = NUM_CH'(1) << addr;
    hdr_empty   = |(fifo_empty & addr_onehot);
  end

  // Everything after the header looks only at the latched channel, so flags
  // from the other channels can never disturb a packet in flight.
  always_comb begin
    sel_full     = |(fifo_full & ch_sel_q);
    sel_empty    = |(fifo_empty & ch_sel_q);
    sel_soft_rst = |(soft_reset & ch_sel_q);
    in_stall     = (state_q == WAIT_TILL_EMPTY) || (state_q == FIFO_FULL_STATE);
  end

  // State register plus channel select, watchdog counter and the registered
  // timeout pulse, all cleared together by the synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= DECODE_ADDRESS;
      ch_sel_q      <= '0;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_sel_q      <= ch_sel_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic. The normal packet flow is computed first, then the
  // watchdog and finally the selected-channel soft reset override it, so the
  // last writer has the highest priority.
  always_comb begin
    state_d       = state_q;
    ch_sel_d      = ch_sel_q;
    wd_cnt_d      = '0;
    timeout_err_d = 1'b0;

    unique case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          if (!addr_valid) begin
            state_d = DROP_PACKET;
          end else begin
            ch_sel_d = addr_onehot;
            state_d  = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
      end
      WAIT_TILL_EMPTY: begin
        if (sel_empty) state_d = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: begin
        state_d = LOAD_DATA;
      end
      LOAD_DATA: begin
        if (sel_full)        state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!sel_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY: begin
        state_d = CHECK_PARITY_ERR;
      end
      CHECK_PARITY_ERR: begin
        state_d = sel_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      DROP_PACKET: begin
        if (!pkt_valid) state_d = DECODE_ADDRESS;
      end
      default: begin
        state_d = DECODE_ADDRESS;
      end
    endcase

    // The watchdog counts only while stalled; any other state leaves the
    // default of zero in place.
    if (in_stall) begin
      wd_cnt_d = wd_cnt_q + TO_W'(1);
      if (WD_EN && (wd_cnt_q == WD_LIMIT)) begin
        state_d       = DECODE_ADDRESS;
        wd_cnt_d      = '0;
        timeout_err_d = 1'b1;
      end
    end

    // A soft reset of the active channel abandons the packet. In
    // DECODE_ADDRESS there is no packet to abandon, so it is ignored there.
    if (sel_soft_rst && (state_q != DECODE_ADDRESS)) begin
      state_d       = DECODE_ADDRESS;
      wd_cnt_d      = '0;
      timeout_err_d = 1'b0;
    end
  end

  // Moore output decodes. busy stays low while dropping because the source
  // must keep streaming the bytes being thrown away.
  always_comb begin
    detect_add    = (state_q == DECODE_ADDRESS);
    lfd_state     = (state_q == LOAD_FIRST_DATA);
    ld_state      = (state_q == LOAD_DATA);
    full_state    = (state_q == FIFO_FULL_STATE);
    laf_state     = (state_q == LOAD_AFTER_FULL);
    rst_int_reg   = (state_q == CHECK_PARITY_ERR);
    drop_state    = (state_q == DROP_PACKET);
    write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                    (state_q == LOAD_AFTER_FULL);
    busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA) ||
                      (state_q == DROP_PACKET));
    ch_sel        = ch_sel_q;
    timeout_err   = timeout_err_q;
  end

endmodule

// File: tb/tb_router_fsm_nch.sv
// ---------------------------------------------------------------------------
// tb_router_fsm_nch
//
// Directed bench for router_fsm_nch with three channels and an eight-cycle
// watchdog. A table of per-cycle vectors walks through the normal packet
// flow, stalls, invalid headers, soft reset and reset; the watchdog abort is
// exercised by a hand-written sequence that counts the stalled cycles.
// Decoded outputs are compared as one vector ordered
// {busy, detect_add, lfd, ld, write_enb, full, laf, rst_int, drop, timeout}.
// ---------------------------------------------------------------------------
module tb_router_fsm_nch;

  localparam int NUM_CH = 3;

  localparam logic [9:0] D_DA   = 10'b0100000000;
  localparam logic [9:0] D_WT   = 10'b1000000000;
  localparam logic [9:0] D_LFD  = 10'b1010000000;
  localparam logic [9:0] D_LD   = 10'b0001100000;
  localparam logic [9:0] D_FFS  = 10'b1000010000;
  localparam logic [9:0] D_LAF  = 10'b1000101000;
  localparam logic [9:0] D_LP   = 10'b1000100000;
  localparam logic [9:0] D_CPE  = 10'b1000000100;
  localparam logic [9:0] D_DROP = 10'b0000000010;
  localparam logic [9:0] D_DATO = 10'b0100000001;

  logic              clock = 1'b0;
  logic              reset;
  logic              pkt_valid;
  logic [7:0]        data_in;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic              parity_done;
  logic              low_pkt_valid;
  logic [NUM_CH-1:0] soft_reset;
  logic [NUM_CH-1:0] ch_sel;
  logic              busy, detect_add, lfd_state, ld_state, write_enb_reg;
  logic              full_state, laf_state, rst_int_reg, drop_state, timeout_err;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    string      name;
    bit         rst;
    bit         pv;
    logic [7:0] data;
    logic [2:0] full;
    logic [2:0] empty;
    bit         pd;
    bit         lpv;
    logic [2:0] srst;
    logic [2:0] expCh;
    logic [9:0] expDec;
  } vec_t;

  vec_t vecs[$];

  router_fsm_nch #(
    .NUM_CH(NUM_CH),
    .DATA_W(8),
    .TIMEOUT_CYCLES(8),
    .TO_W(10)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pkt_valid(pkt_valid),
    .data_in(data_in),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid),
    .soft_reset(soft_reset),
    .ch_sel(ch_sel),
    .busy(busy),
    .detect_add(detect_add),
    .lfd_state(lfd_state),
    .ld_state(ld_state),
    .write_enb_reg(write_enb_reg),
    .full_state(full_state),
    .laf_state(laf_state),
    .rst_int_reg(rst_int_reg),
    .drop_state(drop_state),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  function automatic logic [9:0] decodes();
    return {busy, detect_add, lfd_state, ld_state, write_enb_reg,
            full_state, laf_state, rst_int_reg, drop_state, timeout_err};
  endfunction

  task automatic addVec(input string nm, input bit rst, input bit pv,
                        input logic [7:0] d, input logic [2:0] ff,
                        input logic [2:0] fe, input bit pd, input bit lpv,
                        input logic [2:0] sr, input logic [2:0] ech,
                        input logic [9:0] edec);
    vec_t v;
    v.name = nm; v.rst = rst; v.pv = pv; v.data = d; v.full = ff;
    v.empty = fe; v.pd = pd; v.lpv = lpv; v.srst = sr;
    v.expCh = ech; v.expDec = edec;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    reset         = v.rst;
    pkt_valid     = v.pv;
    data_in       = v.data;
    fifo_full     = v.full;
    fifo_empty    = v.empty;
    parity_done   = v.pd;
    low_pkt_valid = v.lpv;
    soft_reset    = v.srst;
  endtask

  task automatic checkOutput(input string nm, input logic [2:0] expCh,
                             input logic [9:0] expDec);
    testsRun++;
    if (ch_sel !== expCh) begin
      testsFailed++;
      $display("[TB] FAIL %s ch_sel: got %b expected %b", nm, ch_sel, expCh);
    end
    testsRun++;
    if (decodes() !== expDec) begin
      testsFailed++;
      $display("[TB] FAIL %s decodes: got %b expected %b", nm, decodes(), expDec);
    end
  endtask

  task automatic stepCheck(input vec_t v);
    applyStimulus(v);
    @(posedge clock);
    #1;
    checkOutput(v.name, v.expCh, v.expDec);
  endtask

  initial begin
    vec_t v;
    int   fullCycles;

    //      name        rst pv data   full    empty   pd lpv srst    ch      dec
    addVec("reset",      1, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, 3'b000, D_DA);
    addVec("idle",       0, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, 3'b000, D_DA);
    addVec("hdr1",       0, 1, 8'h01, 3'b000, 3'b111, 0, 0, 3'b000, 3'b010, D_LFD);
    addVec("lfd2ld",     0, 1, 8'hAA, 3'b000, 3'b111, 0, 0, 3'b000, 3'b010, D_LD);
    addVec("othfull",    0, 1, 8'hAB, 3'b001, 3'b111, 0, 0, 3'b000, 3'b010, D_LD);
    addVec("ld2lp",      0, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, 3'b010, D_LP);
    addVec("lp2cpe",     0, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, 3'b010, D_CPE);
    addVec("cpe2da",     0, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, 3'b010, D_DA);
    addVec("hdr2wait",   0, 1, 8'h02, 3'b000, 3'b011, 0, 0, 3'b000, 3'b100, D_WT);
    for (int i = 0; i < 4; i++)
      addVec("wait",     0, 1, 8'h10, 3'b000, 3'b011, 0, 0, 3'b000, 3'b100, D_WT);
    addVec("wait2lfd",   0, 1, 8'h11, 3'b000, 3'b111, 0, 0, 3'b000, 3'b100, D_LFD);
    addVec("ch2ld",      0, 1, 8'h12, 3'b000, 3'b111, 0, 0, 3'b000, 3'b100, D_LD);
    addVec("ch2lp",      0, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, 3'b100, D_LP);
    addVec("ch2cpe",     0, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, 3'b100, D_CPE);
    addVec("ch2da",      0, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, 3'b100, D_DA);
    addVec("badhdr",     0, 1, 8'h03, 3'b000, 3'b111, 0, 0, 3'b000, 3'b100, D_DROP);
    addVec("drop1",      0, 1, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, 3'b100, D_DROP);
    addVec("drop2",      0, 1, 8'h01, 3'b000, 3'b111, 0, 0, 3'b000, 3'b100, D_DROP);
    addVec("drop2da",    0, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, 3'b100, D_DA);
    addVec("hdr0",       0, 1, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, 3'b001, D_LFD);
    addVec("ch0ld",      0, 1, 8'h21, 3'b000, 3'b111, 0, 0, 3'b000, 3'b001, D_LD);
    addVec("ch0oth",     0, 1, 8'h22, 3'b010, 3'b111, 0, 0, 3'b000, 3'b001, D_LD);
    addVec("ch0full",    0, 1, 8'h23, 3'b001, 3'b111, 0, 0, 3'b000, 3'b001, D_FFS);
    addVec("ch0hold",    0, 1, 8'h23, 3'b001, 3'b111, 0, 0, 3'b000, 3'b001, D_FFS);
    addVec("ch0laf",     0, 1, 8'h23, 3'b000, 3'b111, 0, 0, 3'b000, 3'b001, D_LAF);
    addVec("laf2lp",     0, 0, 8'h00, 3'b000, 3'b111, 0, 1, 3'b000, 3'b001, D_LP);
    addVec("ch0cpe",     0, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, 3'b001, D_CPE);
    addVec("ch0da",      0, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, 3'b001, D_DA);
    addVec("b_hdr",      0, 1, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, 3'b001, D_LFD);
    addVec("b_ld",       0, 1, 8'h31, 3'b000, 3'b111, 0, 0, 3'b000, 3'b001, D_LD);
    addVec("b_full",     0, 1, 8'h32, 3'b001, 3'b111, 0, 0, 3'b000, 3'b001, D_FFS);
    addVec("b_laf",      0, 1, 8'h32, 3'b000, 3'b111, 0, 0, 3'b000, 3'b001, D_LAF);
    addVec("laf2ld",     0, 1, 8'h33, 3'b000, 3'b111, 0, 0, 3'b000, 3'b001, D_LD);
    addVec("b_full2",    0, 1, 8'h34, 3'b001, 3'b111, 0, 0, 3'b000, 3'b001, D_FFS);
    addVec("b_laf2",     0, 1, 8'h34, 3'b000, 3'b111, 0, 0, 3'b000, 3'b001, D_LAF);
    addVec("laf2da",     0, 0, 8'h00, 3'b000, 3'b111, 1, 1, 3'b000, 3'b001, D_DA);
    addVec("c_hdr",      0, 1, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, 3'b001, D_LFD);
    addVec("c_ld",       0, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, 3'b001, D_LD);
    addVec("c_lp",       0, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, 3'b001, D_LP);
    addVec("c_cpe",      0, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b000, 3'b001, D_CPE);
    addVec("cpe2full",   0, 0, 8'h00, 3'b001, 3'b111, 0, 0, 3'b000, 3'b001, D_FFS);
    addVec("srst_wins",  0, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b001, 3'b001, D_DA);
    addVec("s_hdr",      0, 1, 8'h01, 3'b000, 3'b111, 0, 0, 3'b000, 3'b010, D_LFD);
    addVec("s_ld",       0, 1, 8'h41, 3'b000, 3'b111, 0, 0, 3'b000, 3'b010, D_LD);
    addVec("srst_oth",   0, 1, 8'h42, 3'b000, 3'b111, 0, 0, 3'b100, 3'b010, D_LD);
    addVec("srst_sel",   0, 1, 8'h43, 3'b000, 3'b111, 0, 0, 3'b010, 3'b010, D_DA);
    addVec("srst_idle",  0, 0, 8'h00, 3'b000, 3'b111, 0, 0, 3'b010, 3'b010, D_DA);
    addVec("r_hdr",      0, 1, 8'h01, 3'b000, 3'b111, 0, 0, 3'b000, 3'b010, D_LFD);
    addVec("r_ld",       0, 1, 8'h51, 3'b000, 3'b111, 0, 0, 3'b000, 3'b010, D_LD);
    addVec("midreset",   1, 1, 8'h52, 3'b000, 3'b111, 0, 0, 3'b000, 3'b000, D_DA);

    v = vecs[0];
    applyStimulus(v);
    #2;
    foreach (vecs[i]) stepCheck(vecs[i]);

    // Watchdog: park channel 1 in FIFO_FULL_STATE and count how long it stays.
    v = vecs[0];
    v.rst = 0; v.pv = 1; v.data = 8'h01; v.name = "wd_hdr";
    v.expCh = 3'b010; v.expDec = D_LFD;
    stepCheck(v);
    v.data = 8'h61; v.name = "wd_ld"; v.expDec = D_LD;
    stepCheck(v);
    v.full = 3'b010; v.name = "wd_full"; v.expDec = D_FFS;
    stepCheck(v);
    fullCycles = 1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(v);
      @(posedge clock);
      #1;
      if (!full_state) break;
      fullCycles++;
    end
    testsRun++;
    if (fullCycles != 8) begin
      testsFailed++;
      $display("[TB] FAIL wd_len: got %0d full cycles expected 8", fullCycles);
    end
    checkOutput("wd_abort", 3'b010, D_DATO);
    v.pv = 0; v.full = 3'b000; v.name = "wd_pulse_end";
    v.expDec = D_DA;
    stepCheck(v);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
